// File: rtl/usb_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_scheduler
// Purpose  : Two-requester round-robin USB packet sender (PID, payload, CRC16).
// Revision : 1.0 - initial release
// ============================================================================
module usb_tx_scheduler (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [3:0] ep0_pid,
    input  logic [3:0] ep1_pid,
    input  logic [3:0] ep0_len,
    input  logic [3:0] ep1_len,
    output logic [4:0] buf_addr,
    input  logic [7:0] buf_data,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic [1:0] grant,
    output logic [1:0] done,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PID  = 3'd1,
        S_DATA = 3'd2,
        S_CRC1 = 3'd3,
        S_CRC2 = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_id;
    logic        r_last;
    logic [3:0]  r_pid;
    logic [3:0]  r_len;
    logic [3:0]  r_idx;
    logic [15:0] r_crc;
    logic [1:0]  r_grant;
    logic [1:0]  r_done;

    logic        w_win;
    logic        w_xfer;

    // CRC-16/USB, reflected 0xA001, one byte LSB first
    function automatic logic [15:0] f_crc_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    // On a tie the requester that did not own the last packet wins
    assign w_win  = (req == 2'b11) ? ~r_last : req[1];
    assign w_xfer = tx_valid && tx_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
            r_pid   <= 4'h0;
            r_len   <= 4'h0;
            r_idx   <= 4'h0;
            r_crc   <= 16'hFFFF;
            r_grant <= 2'b00;
            r_done  <= 2'b00;
        end else begin
            r_done <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        r_id    <= w_win;
                        r_last  <= w_win;
                        r_pid   <= w_win ? ep1_pid : ep0_pid;
                        r_len   <= w_win ? ep1_len : ep0_len;
                        r_idx   <= 4'h0;
                        r_crc   <= 16'hFFFF;
                        r_grant <= w_win ? 2'b10 : 2'b01;
                        r_state <= S_PID;
                    end
                end
                S_PID: begin
                    if (w_xfer) begin
                        r_state <= (r_len != 4'h0) ? S_DATA : S_CRC1;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_crc <= f_crc_byte(r_crc, buf_data);
                        r_idx <= r_idx + 4'd1;
                        if (r_idx == r_len - 4'd1) begin
                            r_state <= S_CRC1;
                        end
                    end
                end
                S_CRC1: begin
                    if (w_xfer) begin
                        r_state <= S_CRC2;
                    end
                end
                S_CRC2: begin
                    if (w_xfer) begin
                        r_done  <= r_grant;
                        r_grant <= 2'b00;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_grant <= 2'b00;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        tx_data = 8'h00;
        case (r_state)
            S_PID:   tx_data = {~r_pid, r_pid};
            S_DATA:  tx_data = buf_data;
            S_CRC1:  tx_data = ~r_crc[7:0];
            S_CRC2:  tx_data = ~r_crc[15:8];
            default: tx_data = 8'h00;
        endcase
    end

    assign tx_valid = (r_state == S_PID) || (r_state == S_DATA) ||
                      (r_state == S_CRC1) || (r_state == S_CRC2);
    assign buf_addr = (r_state == S_DATA) ? {r_id, r_idx} : 5'd0;
    assign busy     = (r_state != S_IDLE);
    assign grant    = r_grant;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: doc/usb_tx_scheduler.md
USB_TX_SCHEDULER -- requirements
Module: usb_tx_scheduler

Interface
REQ-001 The block SHALL expose: clk  input  1  single clock; all state advances on its rising edge.
REQ-002 The block SHALL expose: reset  input  1  asynchronous, active-low reset.
REQ-003 The block SHALL expose: req  input  2  per-requester packet request; bit n belongs to requester n.
REQ-004 The block SHALL expose: ep0_pid, ep1_pid  input  4 each  PID of each requester's packet.
REQ-005 The block SHALL expose: ep0_len, ep1_len  input  4 each  payload byte count of each requester's packet, 0..15.
REQ-006 The block SHALL expose: buf_addr  output  5  shared payload buffer address, {granted id, byte index}.
REQ-007 The block SHALL expose: buf_data  input  8  shared buffer read data, combinational from buf_addr.
REQ-008 The block SHALL expose: tx_ready  input  1  downstream transmitter accepts the current byte.
REQ-009 The block SHALL expose: tx_valid  output  1  tx_data holds a valid byte.
REQ-010 The block SHALL expose: tx_data  output  8  byte presented to the transmitter.
REQ-011 The block SHALL expose: grant  output  2  one-hot owner of the tx path; 0 when idle.
REQ-012 The block SHALL expose: done  output  2  one-cycle completion pulse per requester.
REQ-013 The block SHALL expose: busy  output  1  high in any state other than IDLE.

Function
REQ-014 The block SHALL implement the states IDLE, PID, DATA, CRC1 and CRC2.
REQ-015 A byte SHALL transfer only in a cycle where tx_valid and tx_ready are both high; tx_data and tx_valid SHALL hold stable until that transfer.
REQ-016 In IDLE with any req bit high, the block SHALL pick a winner round-robin, and the requester not granted last SHALL win a tie.
REQ-017 On the same IDLE-exit edge, the block SHALL latch the winner's pid and len, set grant one-hot, and enter PID, so tx_valid rises one cycle after req is seen.
REQ-018 In PID, tx_data SHALL be {~pid, pid}; on transfer, the block SHALL go to DATA if len > 0, else to CRC1.
REQ-019 In DATA, buf_addr SHALL be {grant id, idx} with idx starting at 0, and tx_data SHALL equal buf_data.
REQ-020 On each DATA transfer, idx SHALL increment; the transfer of byte len-1 SHALL move the state to CRC1.
REQ-021 The CRC SHALL be CRC-16/USB over the payload bytes only: reflected polynomial 0xA001, init 0xFFFF, final inversion.
REQ-022 The CRC SHALL be updated once per DATA transfer, LSB first, and SHALL be re-initialised on each IDLE exit.
REQ-023 CRC1 SHALL send the inverted CRC low byte and CRC2 the inverted CRC high byte.
REQ-024 On the CRC2 transfer, the block SHALL return to IDLE, clear grant, and pulse done[id] for exactly one cycle, that IDLE cycle.
REQ-025 The block SHALL spend at least one IDLE cycle between packets, with tx_valid low.
REQ-026 Changes on req, pid, len or buf_addr inputs after the grant SHALL be ignored, and the packet SHALL always complete.
REQ-027 With tx_ready held low, the block SHALL stall indefinitely with no state, idx or CRC change.
REQ-028 In IDLE, tx_valid SHALL be 0, tx_data SHALL be 0x00 and buf_addr SHALL be 0.
REQ-029 An unreachable state encoding SHALL return to IDLE on the next clock with tx_valid 0.

Reset
REQ-030 reset low SHALL immediately, without waiting for clk, force: state IDLE, tx_valid 0, tx_data 0x00, grant 00, done 00, busy 0, buf_addr 0, idx 0, CRC 0xFFFF.
REQ-031 Reset SHALL also set the round-robin pointer so that requester 0 wins the first tie.
REQ-032 Reset asserted mid-packet SHALL abort the packet with no done pulse, and the block SHALL resume from IDLE after release.

Verification
REQ-033 The bench SHALL cover: req=01, ep0_pid=0011, len=0, tx_ready=1 -> bytes C3, 00, 00, then done=01 for one cycle.
REQ-034 The bench SHALL cover: req=10, ep1_pid=1011, len=9, buffer holding 31..39 -> bytes 4B, 31..39, C8, B4.
REQ-035 The bench SHALL cover: req=11 held from reset -> grants alternate 01, 10, 01, with one IDLE cycle between packets.
REQ-036 The bench SHALL cover: tx_ready low for 5 cycles during DATA byte 2 -> tx_data constant and buf_addr index 2 held, then the sequence resumes unchanged.
REQ-037 The bench SHALL cover: req dropped to 00 and len changed during DATA -> the packet completes with the latched length and the correct CRC.
REQ-038 The bench SHALL cover: reset pulsed low during CRC1 -> outputs reset asynchronously, done stays 00, and the next req starts at PID.
